// File: rtl/counter_bank.sv
// counter_bank: bank of independent up/down counters with load, terminal pulses and sticky overflow
module counter_bank #(
  parameter int Size     = 5,
  parameter int Channels = 4,
  parameter int Limit    = 2**Size-1,
  parameter int Saturate = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [Channels-1:0]        enable,
  input  logic [Channels-1:0]        up,
  input  logic [Channels-1:0]        load,
  input  logic [Channels*Size-1:0]   load_value,
  input  logic [Channels-1:0]        clear_overflow,
  output logic [Channels*Size-1:0]   count,
  output logic [Channels-1:0]        terminal,
  output logic [Channels-1:0]        overflow
);
  localparam logic [Size-1:0] lim = Size'(Limit);
  localparam logic            sat = Saturate != 0;
  for (genvar g = 0; g < Channels; g++) begin : ch
    logic [Size-1:0] c, lv, nxt;
    logic ev, t, o;
    assign lv = load_value[g*Size +: Size];
    always_comb begin
      ev  = !load[g] && enable[g] && (up[g] ? c == lim : c == '0);
      nxt = load[g] ? (lv > lim ? lim : lv) :
            !enable[g] ? c :
            up[g] ? (c == lim ? (sat ? lim : '0) : c + 1'b1) :
                    (c == '0 ? (sat ? '0 : lim) : c - 1'b1);
    end
    // a boundary event sets overflow even if a clear arrives on the same edge
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        c <= '0;
        t <= 1'b0;
        o <= 1'b0;
      end else begin
        c <= nxt;
        t <= ev;
        o <= ev | (o & ~clear_overflow[g]);
      end
    end
    assign count[g*Size +: Size] = c;
    assign terminal[g] = t;
    assign overflow[g] = o;
  end
endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: three parameterisations driven in lockstep against an arithmetic reference model
module tb_counter_bank;
  logic clock = 0, reset = 0;
  logic [3:0] enable = 0, up = 0, load = 0, clear_overflow = 0;
  logic [19:0] load_value = 0;
  logic [19:0] count0, count1, count2;
  logic [3:0] term0, term1, term2, ovf0, ovf1, ovf2;
  int checks = 0, failures = 0;
  int lim[3] = '{31, 20, 20};
  int sat[3] = '{0, 1, 0};
  int m_cnt[3][4], m_term[3][4], m_ovf[3][4];

  always #5 clock = ~clock;

  counter_bank #(.Size(5), .Channels(4)) dut0 (.clock(clock), .reset(reset), .enable(enable), .up(up),
    .load(load), .load_value(load_value), .clear_overflow(clear_overflow), .count(count0), .terminal(term0), .overflow(ovf0));
  counter_bank #(.Size(5), .Channels(4), .Limit(20), .Saturate(1)) dut1 (.clock(clock), .reset(reset), .enable(enable), .up(up),
    .load(load), .load_value(load_value), .clear_overflow(clear_overflow), .count(count1), .terminal(term1), .overflow(ovf1));
  counter_bank #(.Size(5), .Channels(4), .Limit(20), .Saturate(0)) dut2 (.clock(clock), .reset(reset), .enable(enable), .up(up),
    .load(load), .load_value(load_value), .clear_overflow(clear_overflow), .count(count2), .terminal(term2), .overflow(ovf2));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        m_cnt[k][i] = 0; m_term[k][i] = 0; m_ovf[k][i] = 0;
      end
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_zero();
      return;
    end
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        int c, v, ev;
        c = m_cnt[k][i];
        v = int'(load_value[i*5 +: 5]);
        ev = 0;
        if (load[i]) c = (v > lim[k]) ? lim[k] : v;
        else if (enable[i] && up[i]) begin
          if (c < lim[k]) c = c + 1;
          else begin ev = 1; c = sat[k] ? lim[k] : 0; end
        end else if (enable[i]) begin
          if (c > 0) c = c - 1;
          else begin ev = 1; c = sat[k] ? 0 : lim[k]; end
        end
        m_cnt[k][i] = c;
        m_term[k][i] = ev;
        m_ovf[k][i] = ev ? 1 : (clear_overflow[i] ? 0 : m_ovf[k][i]);
      end
  endtask

  task automatic cmp_inst(input int k, input logic [19:0] c, input logic [3:0] t, input logic [3:0] o);
    int ec, et, eo;
    ec = 0; et = 0; eo = 0;
    for (int i = 0; i < 4; i++) begin
      ec |= m_cnt[k][i] << (i*5);
      et |= m_term[k][i] << i;
      eo |= m_ovf[k][i] << i;
    end
    check($sformatf("count%0d", k), int'(c), ec);
    check($sformatf("terminal%0d", k), int'(t), et);
    check($sformatf("overflow%0d", k), int'(o), eo);
  endtask

  task automatic compare();
    cmp_inst(0, count0, term0, ovf0);
    cmp_inst(1, count1, term1, ovf1);
    cmp_inst(2, count2, term2, ovf2);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input logic [3:0] e, input logic [3:0] u, input logic [3:0] l,
                       input logic [19:0] v, input logic [3:0] cl);
    enable = e; up = u; load = l; load_value = v; clear_overflow = cl;
  endtask

  initial begin
    model_zero();
    drive(4'hf, 4'hf, 4'hf, 20'hfffff, 4'hf);
    repeat (3) step();
    drive(0, 0, 0, 0, 0);
    reset = 1;
    repeat (10) step();
    // channel 0 counts up through the wrap
    drive(4'b0001, 4'b0001, 0, 0, 0);
    repeat (33) step();
    // channel 1: load 18 then count up into the boundary
    drive(0, 0, 4'b0010, 20'd18 << 5, 0);
    step();
    drive(4'b0010, 4'b0010, 0, 0, 0);
    repeat (5) step();
    // channel 2: clamped load, then count down through zero
    drive(0, 0, 4'b0100, 20'd31 << 10, 0);
    step();
    drive(0, 0, 4'b0100, 20'd1 << 10, 0);
    step();
    drive(4'b0100, 4'b0000, 0, 0, 0);
    repeat (3) step();
    // channel 3: event and clear on the same edge, then clear alone
    drive(0, 0, 4'b1000, 0, 0);
    step();
    drive(4'b1000, 0, 0, 0, 0);
    step();
    drive(0, 0, 4'b1000, 0, 0);
    step();
    drive(4'b1000, 0, 0, 0, 4'b1000);
    step();
    drive(0, 0, 0, 0, 4'b1000);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    // channel 0 at 12 and counting; asynchronous reset between edges
    drive(0, 0, 4'b0001, 20'd12, 0);
    step();
    drive(4'b0001, 4'b0001, 0, 0, 0);
    step();
    #2 reset = 0;
    #1 model_zero();
    compare();
    repeat (2) step();
    reset = 1;
    repeat (4) step();
    for (int n = 0; n < 500; n++) begin
      drive(4'($urandom), 4'($urandom), 4'($urandom & $urandom & $urandom), 20'($urandom), 4'($urandom & $urandom));
      if ($urandom_range(0, 99) == 0) begin
        step();
        #2 reset = 0;
        #1 model_zero();
        compare();
        step();
        reset = 1;
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
